// File: rtl/cmos_dvp_tx.sv
// cmos_dvp_tx: DVP sensor emulator. Turns a byte stream into a pclk-synchronous
// raster (vsync / href / 8-bit data). Once a frame starts its timing is
// free-running; a missing stream byte inside a line is replaced by FILL_BYTE.
//
// Ports
//   cmos_pclk, cmos_rst_n     : clock (rising edge), async active-low reset
//   enable                    : start frames / continue after the current frame
//   s_data/s_valid/s_sof      : input byte stream, s_sof marks first byte of a frame
//   s_ready                   : byte consumed when s_valid & s_ready (combinational)
//   cmos_href/vsync/data      : registered DVP outputs (1-cycle latency)
//   busy                      : not IDLE
//   frame_done/underrun/sof_err : 1-cycle status pulses (registered)
module cmos_dvp_tx #(
    parameter int         H_ACTIVE    = 640,
    parameter int         V_ACTIVE    = 480,
    parameter int         VSYNC_CYC   = 3,
    parameter int         V_BP_CYC    = 16,
    parameter int         H_BLANK_CYC = 144,
    parameter int         V_FP_CYC    = 10,
    parameter logic [7:0] FILL_BYTE   = 8'h00
) (
    input  logic       cmos_pclk,
    input  logic       cmos_rst_n,
    input  logic       enable,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_sof,
    output logic       s_ready,
    output logic       cmos_href,
    output logic       cmos_vsync,
    output logic [7:0] cmos_data,
    output logic       busy,
    output logic       frame_done,
    output logic       underrun,
    output logic       sof_err
);

    typedef enum logic [2:0] {
        IDLE, WAIT_SOF, VSYNC, V_BP, LINE, H_BLANK, V_FP
    } state_e;

    // Each timed state loads its length-1 and leaves when the count hits 0.
    localparam logic [15:0] VS_LAST = 16'(VSYNC_CYC - 1);
    localparam logic [15:0] BP_LAST = 16'(V_BP_CYC - 1);
    localparam logic [15:0] HA_LAST = 16'(H_ACTIVE - 1);
    localparam logic [15:0] HB_LAST = 16'(H_BLANK_CYC - 1);
    localparam logic [15:0] FP_LAST = 16'(V_FP_CYC - 1);
    localparam logic [15:0] VA_LAST = 16'(V_ACTIVE - 1);

    state_e      state_q, state_d;
    logic [15:0] cyc_cnt_q, cyc_cnt_d;
    logic [15:0] line_cnt_q, line_cnt_d;
    logic        href_q, href_d;
    logic        vsync_q, vsync_d;
    logic [7:0]  data_q, data_d;
    logic        frame_done_q, frame_done_d;
    logic        underrun_q, underrun_d;
    logic        sof_err_q, sof_err_d;
    logic        cnt_last;
    logic        first_byte;

    assign cnt_last   = (cyc_cnt_q == 16'd0);
    // Position of the frame's first LINE byte; an s_sof here is the expected one.
    assign first_byte = (line_cnt_q == 16'd0) && (cyc_cnt_q == HA_LAST);

    // State register
    always_ff @(posedge cmos_pclk or negedge cmos_rst_n) begin
        if (!cmos_rst_n) begin
            state_q    <= IDLE;
            cyc_cnt_q  <= 16'd0;
            line_cnt_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            cyc_cnt_q  <= cyc_cnt_d;
            line_cnt_q <= line_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        cyc_cnt_d  = cnt_last ? 16'd0 : cyc_cnt_q - 16'd1;
        line_cnt_d = line_cnt_q;
        case (state_q)
            IDLE: begin
                cyc_cnt_d  = 16'd0;
                line_cnt_d = 16'd0;
                if (enable) state_d = WAIT_SOF;
            end
            WAIT_SOF: begin
                cyc_cnt_d  = 16'd0;
                line_cnt_d = 16'd0;
                if (!enable) begin
                    state_d = IDLE;
                end else if (s_valid && s_sof) begin
                    state_d   = VSYNC;
                    cyc_cnt_d = VS_LAST;
                end
            end
            VSYNC: if (cnt_last) begin
                state_d   = V_BP;
                cyc_cnt_d = BP_LAST;
            end
            V_BP: if (cnt_last) begin
                state_d   = LINE;
                cyc_cnt_d = HA_LAST;
            end
            LINE: if (cnt_last) begin
                state_d   = H_BLANK;
                cyc_cnt_d = HB_LAST;
            end
            H_BLANK: if (cnt_last) begin
                if (line_cnt_q == VA_LAST) begin
                    state_d   = V_FP;
                    cyc_cnt_d = FP_LAST;
                end else begin
                    state_d    = LINE;
                    cyc_cnt_d  = HA_LAST;
                    line_cnt_d = line_cnt_q + 16'd1;
                end
            end
            V_FP: if (cnt_last) begin
                state_d   = enable ? WAIT_SOF : IDLE;
                cyc_cnt_d = 16'd0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        // In WAIT_SOF, junk bytes are drained while the SOF byte is held for LINE.
        s_ready      = (state_q == LINE) || ((state_q == WAIT_SOF) && !s_sof);
        busy         = (state_q != IDLE);
        href_d       = (state_q == LINE);
        vsync_d      = (state_q == VSYNC);
        data_d       = data_q;
        underrun_d   = 1'b0;
        sof_err_d    = 1'b0;
        frame_done_d = (state_q == V_FP) && cnt_last;
        if (state_q == LINE) begin
            data_d     = s_valid ? s_data : FILL_BYTE;
            underrun_d = !s_valid;
            sof_err_d  = s_valid && s_sof && !first_byte;
        end
    end

    always_ff @(posedge cmos_pclk or negedge cmos_rst_n) begin
        if (!cmos_rst_n) begin
            href_q       <= 1'b0;
            vsync_q      <= 1'b0;
            data_q       <= 8'h00;
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
            sof_err_q    <= 1'b0;
        end else begin
            href_q       <= href_d;
            vsync_q      <= vsync_d;
            data_q       <= data_d;
            frame_done_q <= frame_done_d;
            underrun_q   <= underrun_d;
            sof_err_q    <= sof_err_d;
        end
    end

    assign cmos_href  = href_q;
    assign cmos_vsync = vsync_q;
    assign cmos_data  = data_q;
    assign frame_done = frame_done_q;
    assign underrun   = underrun_q;
    assign sof_err    = sof_err_q;

endmodule

// File: tb/tb_cmos_dvp_tx.sv
// Bench for cmos_dvp_tx with a small raster (4x2, frame = 19 cycles).
// A source queue feeds the stream; expected href bytes go to a scoreboard
// queue as stimulus is queued and are popped on every href cycle.
module tb_cmos_dvp_tx;

    localparam int         H_ACTIVE    = 4;
    localparam int         V_ACTIVE    = 2;
    localparam int         VSYNC_CYC   = 2;
    localparam int         V_BP_CYC    = 3;
    localparam int         H_BLANK_CYC = 2;
    localparam int         V_FP_CYC    = 2;
    localparam logic [7:0] FILL        = 8'h00;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       s_valid = 1'b0;
    logic       s_sof = 1'b0;
    logic       s_ready, cmos_href, cmos_vsync, busy, frame_done, underrun, sof_err;
    logic [7:0] cmos_data;

    cmos_dvp_tx #(
        .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .VSYNC_CYC(VSYNC_CYC),
        .V_BP_CYC(V_BP_CYC), .H_BLANK_CYC(H_BLANK_CYC), .V_FP_CYC(V_FP_CYC),
        .FILL_BYTE(FILL)
    ) dut (
        .cmos_pclk(clk), .cmos_rst_n(rst_n), .enable(enable),
        .s_data(s_data), .s_valid(s_valid), .s_sof(s_sof), .s_ready(s_ready),
        .cmos_href(cmos_href), .cmos_vsync(cmos_vsync), .cmos_data(cmos_data),
        .busy(busy), .frame_done(frame_done), .underrun(underrun), .sof_err(sof_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       v;
        logic       sof;
        logic [7:0] d;
    } item_t;

    item_t      src_q[$];
    logic [7:0] exp_q[$];
    int n_chk = 0, n_pass = 0;
    bit presented = 0, hs = 0;

    // frame statistics; t is cycles since the first vsync-high sample
    int t = 0, vs_hi = 0, n_rise = 0, href_cyc = 0, drops = 0;
    int und_cnt = 0, und_t = -1, serr_cnt = 0, serr_t = -1, fd_cnt = 0, fd_t = -1;
    int rise_t[4];
    bit vs_prev = 0, href_prev = 0;

    // Source driver: gap items (v=0) last one cycle, bytes wait for handshake.
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            src_q.delete();
            presented = 0;
        end else if (presented && src_q.size() > 0 && (!src_q[0].v || hs)) begin
            src_q.delete(0);
            presented = 0;
        end
        if (rst_n && src_q.size() > 0) begin
            s_valid   = src_q[0].v;
            s_sof     = src_q[0].sof;
            s_data    = src_q[0].d;
            presented = 1;
        end else begin
            s_valid   = 1'b0;
            s_sof     = 1'b0;
            presented = 0;
        end
    end

    // Monitor + scoreboard
    always @(negedge clk) begin
        logic [7:0] e;
        hs = s_valid && s_ready;
        if (rst_n) begin
            if (cmos_vsync && !vs_prev) t = 0; else t++;
            vs_prev = cmos_vsync;
            if (cmos_vsync) vs_hi++;
            if (hs && !s_sof && vs_hi == 0) drops++;
            if (cmos_href) begin
                if (!href_prev && n_rise < 4) begin rise_t[n_rise] = t; n_rise++; end
                href_cyc++;
                n_chk++;
                if (exp_q.size() == 0) begin
                    $display("FAIL href_data: unexpected href byte %02h, scoreboard empty", cmos_data);
                end else begin
                    e = exp_q.pop_front();
                    if (cmos_data !== e) $display("FAIL href_data: got %02h want %02h at t=%0d", cmos_data, e, t);
                    else n_pass++;
                end
            end
            href_prev = cmos_href;
            if (underrun)   begin und_cnt++;  und_t = t;  end
            if (sof_err)    begin serr_cnt++; serr_t = t; end
            if (frame_done) begin fd_cnt++;   fd_t = t;   end
        end
    end

    task automatic tick();
        @(negedge clk); #1;
    endtask

    task automatic clear_stats();
        t = 0; vs_hi = 0; n_rise = 0; href_cyc = 0; drops = 0;
        und_cnt = 0; und_t = -1; serr_cnt = 0; serr_t = -1; fd_cnt = 0; fd_t = -1;
    endtask

    task automatic push(input logic v, input logic sof, input logic [7:0] d);
        item_t it;
        it.v = v; it.sof = sof; it.d = d;
        src_q.push_back(it);
    endtask

    task automatic wait_fd(input string name);
        int k = 0;
        while (fd_cnt == 0 && k < 80) begin tick(); k++; end
        if (fd_cnt == 0) begin
            n_chk++;
            $display("FAIL %s_timeout: no frame_done within 80 cycles", name);
        end
        tick();
    endtask

    task automatic test_reset();
        tick();
        n_chk++;
        if ({cmos_href, cmos_vsync, cmos_data, busy, frame_done, underrun, sof_err, s_ready} !== 14'h0)
            $display("FAIL reset_outputs: got href=%b vs=%b data=%02h busy=%b fd=%b ur=%b se=%b rdy=%b want all 0",
                     cmos_href, cmos_vsync, cmos_data, busy, frame_done, underrun, sof_err, s_ready);
        else n_pass++;
        rst_n = 1'b1;
        enable = 1'b1;
        tick(); tick();
        n_chk++;
        if (busy !== 1'b1 || cmos_vsync !== 1'b0) $display("FAIL reset_wait_sof: busy=%b vsync=%b want 1/0", busy, cmos_vsync);
        else n_pass++;
    endtask

    task automatic test_basic();
        clear_stats();
        for (int i = 1; i <= 8; i++) begin
            push(1'b1, i == 1, 8'(i));
            exp_q.push_back(8'(i));
        end
        wait_fd("basic");
        n_chk++; if (vs_hi !== 2) $display("FAIL basic_vsync_len: got %0d want 2", vs_hi); else n_pass++;
        n_chk++; if (rise_t[0] !== 5) $display("FAIL basic_line0_start: got %0d want 5", rise_t[0]); else n_pass++;
        n_chk++; if (rise_t[1] !== 11) $display("FAIL basic_line1_start: got %0d want 11", rise_t[1]); else n_pass++;
        n_chk++; if (href_cyc !== 8) $display("FAIL basic_href_cycles: got %0d want 8", href_cyc); else n_pass++;
        n_chk++; if (fd_t !== 18 || fd_cnt !== 1) $display("FAIL basic_frame_done: t=%0d cnt=%0d want 18/1", fd_t, fd_cnt); else n_pass++;
        n_chk++; if (und_cnt !== 0 || serr_cnt !== 0) $display("FAIL basic_no_err: ur=%0d se=%0d want 0/0", und_cnt, serr_cnt); else n_pass++;
        n_chk++; if (exp_q.size() !== 0) $display("FAIL basic_sb_empty: %0d left want 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_drop();
        int k = 0;
        clear_stats();
        for (int i = 0; i < 5; i++) push(1'b1, 1'b0, 8'hAA + 8'(i));
        for (int i = 0; i < 8; i++) begin
            push(1'b1, i == 0, 8'h10 + 8'(i));
            exp_q.push_back(8'h10 + 8'(i));
        end
        while (!(s_valid && s_sof) && k < 20) begin tick(); k++; end
        n_chk++;
        if (!(s_valid && s_sof)) $display("FAIL drop_sof_timeout: SOF byte never presented");
        else if (s_ready !== 1'b0) $display("FAIL drop_sof_held: s_ready=%b want 0", s_ready);
        else n_pass++;
        wait_fd("drop");
        n_chk++; if (drops !== 5) $display("FAIL drop_count: got %0d want 5", drops); else n_pass++;
        n_chk++; if (rise_t[0] !== 5 || fd_t !== 18) $display("FAIL drop_timing: rise=%0d fd=%0d want 5/18", rise_t[0], fd_t); else n_pass++;
    endtask

    task automatic test_underrun();
        clear_stats();
        push(1'b1, 1'b1, 8'h01); exp_q.push_back(8'h01);
        push(1'b1, 1'b0, 8'h02); exp_q.push_back(8'h02);
        push(1'b0, 1'b0, 8'hEE); exp_q.push_back(FILL);
        for (int i = 3; i <= 7; i++) begin
            push(1'b1, 1'b0, 8'(i));
            exp_q.push_back(8'(i));
        end
        wait_fd("underrun");
        n_chk++; if (und_cnt !== 1 || und_t !== 7) $display("FAIL underrun_pulse: cnt=%0d t=%0d want 1/7", und_cnt, und_t); else n_pass++;
        n_chk++; if (href_cyc !== 8 || fd_t !== 18) $display("FAIL underrun_timing: href=%0d fd=%0d want 8/18", href_cyc, fd_t); else n_pass++;
    endtask

    task automatic test_sof_err();
        clear_stats();
        for (int i = 1; i <= 8; i++) begin
            push(1'b1, (i == 1) || (i == 6), 8'h20 + 8'(i));
            exp_q.push_back(8'h20 + 8'(i));
        end
        wait_fd("soferr");
        n_chk++; if (serr_cnt !== 1 || serr_t !== 12) $display("FAIL soferr_pulse: cnt=%0d t=%0d want 1/12", serr_cnt, serr_t); else n_pass++;
        n_chk++; if (und_cnt !== 0 || href_cyc !== 8 || fd_t !== 18) $display("FAIL soferr_timing: ur=%0d href=%0d fd=%0d want 0/8/18", und_cnt, href_cyc, fd_t); else n_pass++;
    endtask

    task automatic test_disable();
        int k = 0;
        int vs0;
        clear_stats();
        for (int i = 1; i <= 8; i++) begin
            push(1'b1, i == 1, 8'h40 + 8'(i));
            exp_q.push_back(8'h40 + 8'(i));
        end
        while (n_rise < 2 && k < 40) begin tick(); k++; end
        enable = 1'b0;
        wait_fd("disable");
        n_chk++; if (fd_cnt !== 1 || fd_t !== 18) $display("FAIL disable_frame_done: cnt=%0d t=%0d want 1/18", fd_cnt, fd_t); else n_pass++;
        tick();
        n_chk++; if (busy !== 1'b0) $display("FAIL disable_idle: busy=%b want 0", busy); else n_pass++;
        vs0 = vs_hi;
        push(1'b1, 1'b1, 8'h99);
        for (int i = 0; i < 30; i++) tick();
        n_chk++; if (vs_hi !== vs0 || busy !== 1'b0 || s_ready !== 1'b0) $display("FAIL disable_stays_idle: vs=%0d busy=%b rdy=%b want %0d/0/0", vs_hi, busy, s_ready, vs0); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int k = 0;
        clear_stats();
        src_q.delete();
        for (int i = 1; i <= 8; i++) begin
            push(1'b1, i == 1, 8'h50 + 8'(i));
            exp_q.push_back(8'h50 + 8'(i));
        end
        enable = 1'b1;
        while (n_rise < 1 && k < 40) begin tick(); k++; end
        tick();
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({cmos_href, cmos_vsync, cmos_data, s_ready, busy} !== 12'h0)
            $display("FAIL rstmid_outputs: href=%b vs=%b data=%02h rdy=%b busy=%b want all 0", cmos_href, cmos_vsync, cmos_data, s_ready, busy);
        else n_pass++;
        tick(); tick();
        exp_q.delete();
        rst_n = 1'b1;
        clear_stats();
        for (int i = 0; i < 5; i++) tick();
        n_chk++;
        if (busy !== 1'b1 || s_ready !== 1'b1 || vs_hi !== 0) $display("FAIL rstmid_wait_sof: busy=%b rdy=%b vs=%0d want 1/1/0", busy, s_ready, vs_hi);
        else n_pass++;
        for (int i = 1; i <= 8; i++) begin
            push(1'b1, i == 1, 8'h60 + 8'(i));
            exp_q.push_back(8'h60 + 8'(i));
        end
        wait_fd("recover");
        n_chk++; if (href_cyc !== 8 || fd_t !== 18 || exp_q.size() !== 0) $display("FAIL recover_frame: href=%0d fd=%0d left=%0d want 8/18/0", href_cyc, fd_t, exp_q.size()); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_drop();
        test_underrun();
        test_sof_err();
        test_disable();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
